queue_drain_ctrl: RTL and testbench

- Sequences the read side of the word queue. Watches the queue occupancy, issues single-cycle dequeue pulses and captures the head word.
- Presents each captured word to a downstream consumer over a valid/ready handshake.
- Replaces manual dequeue_in driving in top. Supports threshold-triggered burst drain and an explicit flush.

---
 rtl/queue_drain_pkg.sv | 14 +
 rtl/queue_drain_ctrl_if.sv | 25 ++
 rtl/queue_drain_ctrl.sv | 99 +++++++++
 tb/tb_queue_drain_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_drain_pkg.sv
// Shared types and default widths for the queue read-side drain controller.
package queue_drain_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int unsigned DEF_LEN_W  = 4;
   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/queue_drain_ctrl_if.sv
// Queue-side pop/head signals plus the downstream valid/ready word channel.
interface queue_drain_ctrl_if #(
   parameter int unsigned LEN_W  = queue_drain_pkg::DEF_LEN_W,
   parameter int unsigned DATA_W = queue_drain_pkg::DEF_DATA_W
);

   logic [LEN_W-1:0]  len_in;
   logic [DATA_W-1:0] qdata_in;
   logic              dequeue_out;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              ready_in;

   // master: the drain controller; slave: the queue plus the consumer
   modport master (
      input  len_in, qdata_in, ready_in,
      output dequeue_out, data_out, valid_out
   );

   modport slave (
      output len_in, qdata_in, ready_in,
      input  dequeue_out, data_out, valid_out
   );

endinterface

// File: rtl/queue_drain_ctrl.sv
// Read-side sequencer for the word queue: threshold/flush-triggered drain,
// one outstanding word, delivered downstream over valid/ready.
module queue_drain_ctrl
   import queue_drain_pkg::*;
#(
   parameter int unsigned LEN_W  = DEF_LEN_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned THRESH = 4,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable_in,
   input  logic             flush_in,
   queue_drain_ctrl_if.master q,
   output logic             busy_out,
   output logic [CNT_W-1:0] count_out
);

   localparam int unsigned THRESH_C = (THRESH == 0) ? 1 : THRESH;

   state_t            state, state_nxt;
   logic              drain, drain_nxt;
   logic              flush_pend, flush_pend_nxt;
   logic              dequeue_nxt, valid_nxt, busy_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic [CNT_W-1:0]  count_nxt;
   logic              q_empty, at_thresh, start, accept;

   assign q_empty   = (q.len_in == '0);
   assign at_thresh = (32'(q.len_in) >= THRESH_C);
   assign accept    = q.valid_out && q.ready_in;
   assign start     = (state == IDLE) && enable_in && !q_empty && !q.valid_out &&
                      (drain || flush_pend || at_thresh);

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         drain         <= 1'b0;
         flush_pend    <= 1'b0;
         q.dequeue_out <= 1'b0;
         q.valid_out   <= 1'b0;
         q.data_out    <= '0;
         busy_out      <= 1'b0;
         count_out     <= '0;
      end else begin
         state         <= state_nxt;
         drain         <= drain_nxt;
         flush_pend    <= flush_pend_nxt;
         q.dequeue_out <= dequeue_nxt;
         q.valid_out   <= valid_nxt;
         q.data_out    <= data_nxt;
         busy_out      <= busy_nxt;
         count_out     <= count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = POP;
         POP:     state_nxt = HOLD;
         HOLD:    if (accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      dequeue_nxt    = start;
      valid_nxt      = q.valid_out;
      data_nxt       = q.data_out;
      count_nxt      = count_out;
      drain_nxt      = drain;
      flush_pend_nxt = flush_pend;
      unique case (state)
         IDLE: begin
            if (start) begin
               data_nxt  = q.qdata_in;
               drain_nxt = 1'b1;
            end else if (q_empty) begin
               drain_nxt      = 1'b0;
               flush_pend_nxt = 1'b0;
            end
         end
         POP:  valid_nxt = 1'b1;
         HOLD: begin
            if (accept) begin
               valid_nxt = 1'b0;
               count_nxt = count_out + CNT_W'(1);
            end
         end
         default: ;
      endcase
      // a new flush request wins over the empty-queue clear in the same cycle
      if (flush_in) flush_pend_nxt = 1'b1;
      busy_nxt = drain_nxt | flush_pend_nxt;
   end

endmodule

// File: tb/tb_queue_drain_ctrl.sv
// Scoreboard bench: behavioural FIFO feeds the controller, popped words are
// expected downstream in order; a narrow-counter instance checks wrap.
module tb_queue_drain_ctrl;

   logic        clock = 1'b0;
   logic        reset, reset2;
   logic        enable, flush;
   logic        busy, busy2;
   logic [15:0] count;
   logic [3:0]  count2;

   queue_drain_ctrl_if #(.LEN_W(4), .DATA_W(8)) qif ();
   queue_drain_ctrl_if #(.LEN_W(4), .DATA_W(8)) qif2 ();

   queue_drain_ctrl #(.LEN_W(4), .DATA_W(8), .THRESH(4), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .enable_in(enable), .flush_in(flush),
      .q(qif.master), .busy_out(busy), .count_out(count)
   );

   queue_drain_ctrl #(.LEN_W(4), .DATA_W(8), .THRESH(4), .CNT_W(4)) dut2 (
      .clock(clock), .reset(reset2), .enable_in(1'b1), .flush_in(1'b0),
      .q(qif2.master), .busy_out(busy2), .count_out(count2)
   );

   always #5 clock = ~clock;

   int          total = 0, bad = 0;
   logic [7:0]  fifo[$];
   logic [7:0]  exp_q[$];
   logic [15:0] exp_cnt = '0;
   int          cyc = 0, pulses = 0, last_pulse = -100;
   int          pulse_cyc[$];
   bit          deq_seen = 1'b0;
   logic [3:0]  prev_len = '0;
   logic        prev_valid = 1'b0, prev_en = 1'b0;
   int          h2 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // monitor: pop legality, pulse spacing and scoreboard compare on handshake
   always @(negedge clock) begin
      cyc++;
      deq_seen = qif.dequeue_out;
      if (!reset && qif.dequeue_out) begin
         pulses++;
         check("pop_spacing", 32'(cyc - last_pulse >= 3), 1);
         check("pop_legal", 32'(prev_len != 0 && prev_en && !prev_valid && !qif.valid_out), 1);
         last_pulse = cyc;
         pulse_cyc.push_back(cyc);
      end
      if (!reset && qif.valid_out && qif.ready_in) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL word_unexpected: got %0h want none", qif.data_out);
         end else begin
            check("word", 32'(qif.data_out), 32'(exp_q.pop_front()));
         end
         check("count_at_handshake", 32'(count), 32'(exp_cnt));
         exp_cnt++;
      end
      prev_len   = qif.len_in;
      prev_valid = qif.valid_out;
      prev_en    = enable;
   end

   always @(negedge clock) begin
      if (!reset2 && qif2.valid_out && qif2.ready_in && h2 < 20) begin
         check("wrap_word", 32'(qif2.data_out), 32'h3C);
         check("wrap_count", 32'(count2), 32'(h2[3:0]));
         h2++;
      end
   end

   task automatic step(input bit push = 1'b0, input logic [7:0] d = 8'h00, input bit fl = 1'b0);
      @(posedge clock);
      #1;
      if (deq_seen && fifo.size() > 0) exp_q.push_back(fifo.pop_front());
      if (push) fifo.push_back(d);
      flush        = fl;
      qif.len_in   = 4'(fifo.size());
      qif.qdata_in = (fifo.size() > 0) ? fifo[0] : 8'h00;
   endtask

   task automatic drain_wait(input string name, input int lim);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(fifo.size() == 0 && !qif.valid_out && !busy && !qif.dequeue_out) && n < lim);
      total++;
      if (n >= lim) begin
         bad++;
         $display("FAIL %s: got no drain after %0d cycles want drained", name, n);
      end
   endtask

   task automatic wait_valid(input string name, input int lim);
      int n = 0;
      while (!qif.valid_out && n < lim) begin
         step();
         n++;
      end
      total++;
      if (!qif.valid_out) begin
         bad++;
         $display("FAIL %s: got valid_out=0 want 1 within %0d cycles", name, lim);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_dequeue"}, 32'(qif.dequeue_out), 0);
      check({tag, "_valid"},   32'(qif.valid_out), 0);
      check({tag, "_data"},    32'(qif.data_out), 0);
      check({tag, "_busy"},    32'(busy), 0);
      check({tag, "_count"},   32'(count), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, c0, n;
      logic [7:0] hold_d;
      bit stable;
      reset = 1'b1; reset2 = 1'b1; enable = 1'b1; flush = 1'b0;
      qif.ready_in = 1'b1; qif.len_in = '0; qif.qdata_in = '0;
      qif2.ready_in = 1'b1; qif2.len_in = 4'd5; qif2.qdata_in = 8'h3C;
      repeat (3) step();
      @(negedge clock);
      check_outputs_zero("reset");
      step();
      reset = 1'b0; reset2 = 1'b0;

      // threshold burst
      step(1'b1, 8'h99); repeat (3) step();
      step(1'b1, 8'hF0); repeat (3) step();
      step(1'b1, 8'h0F); repeat (6) step();
      check("no_pop_below_thresh", 32'(pulses), 0);
      p0 = pulse_cyc.size();
      step(1'b1, 8'hAA);
      step(); step();
      @(negedge clock);
      check("burst_busy", 32'(busy), 1);
      drain_wait("burst_drain", 60);
      check("burst_pulses", 32'(pulses), 4);
      for (int i = 1; i < 4; i++)
         check("burst_spacing", 32'(pulse_cyc[p0+i] - pulse_cyc[p0+i-1]), 3);
      check("burst_count", 32'(count), 4);
      check("burst_busy_end", 32'(busy), 0);

      // backpressure
      qif.ready_in = 1'b0;
      p0 = pulses;
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h31 + i));
      wait_valid("bp_valid", 10);
      hold_d = qif.data_out;
      check("bp_data", 32'(hold_d), 32'h31);
      stable = 1'b1;
      repeat (20) begin
         step();
         if (!qif.valid_out || qif.data_out !== hold_d) stable = 1'b0;
      end
      check("bp_stable", 32'(stable), 1);
      check("bp_one_pop", 32'(pulses - p0), 1);
      c0 = count;
      qif.ready_in = 1'b1;
      step();
      @(negedge clock);
      check("bp_count_inc", 32'(count), 32'(c0 + 1));
      drain_wait("bp_drain", 60);

      // flush below threshold
      p0 = pulses;
      step(1'b1, 8'h99); step(1'b1, 8'hF0); repeat (5) step();
      check("flush_no_pop_before", 32'(pulses - p0), 0);
      c0 = count;
      step(1'b0, 8'h00, 1'b1);
      step();
      drain_wait("flush_drain", 40);
      check("flush_count", 32'(count - c0), 2);
      check("flush_busy_clear", 32'(busy), 0);
      p0 = pulses;
      step(1'b1, 8'h5E); repeat (8) step();
      check("flush_single_no_pop", 32'(pulses - p0), 0);

      // enable gating
      qif.ready_in = 1'b0;
      c0 = count;
      step(1'b1, 8'h21); step(1'b1, 8'h22); step(1'b1, 8'h23);
      wait_valid("en_valid", 10);
      check("en_hold_data", 32'(qif.data_out), 32'h5E);
      enable = 1'b0;
      step();
      qif.ready_in = 1'b1;
      step();
      p0 = pulses;
      repeat (10) step();
      @(negedge clock);
      check("en_no_pop", 32'(pulses - p0), 0);
      check("en_handshake_done", 32'(count - c0), 1);
      check("en_drain_kept", 32'(busy), 1);
      enable = 1'b1;
      drain_wait("en_drain", 40);
      check("en_count", 32'(count - c0), 4);

      // reset during POP
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h41 + i));
      n = 0;
      while (!qif.dequeue_out && n < 20) begin
         step();
         n++;
      end
      check("rst_pop_seen", 32'(qif.dequeue_out), 1);
      reset = 1'b1;
      step();
      exp_q.delete();
      exp_cnt = '0;
      @(negedge clock);
      check_outputs_zero("rst_mid");
      step();
      reset = 1'b0;
      p0 = pulses;
      repeat (6) step();
      check("rst_no_stale_drain", 32'(pulses - p0), 0);
      step(1'b1, 8'h45);
      drain_wait("rst_burst", 60);
      check("rst_burst_count", 32'(count), 4);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         qif.ready_in = ($urandom_range(0, 3) != 0);
         enable       = ($urandom_range(0, 7) != 0);
         step((fifo.size() < 14) && ($urandom_range(0, 2) == 0), 8'($urandom),
              ($urandom_range(0, 40) == 0));
      end
      enable = 1'b1;
      qif.ready_in = 1'b1;
      step(1'b0, 8'h00, 1'b1);
      drain_wait("rand_drain", 300);
      check("rand_scoreboard_empty", 32'(exp_q.size()), 0);
      check("rand_count", 32'(count), 32'(exp_cnt));
      check("wrap_words_seen", 32'(h2), 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
